// File: rtl/mcp_pkg.sv
// mcp_pkg: opcodes, FSM states and instruction field positions for the multicycle core
package mcp_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_BZ   = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;
  localparam int IMM_W  = 8;
endpackage

// File: rtl/mcp_regfile.sv
// mcp_regfile: NREGS x DATA_W register file, sync write, two operand reads plus a debug read
module mcp_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b,
  output logic [DATA_W-1:0]        dbg_rdata
);
  logic [DATA_W-1:0] regs [NREGS];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we) regs[waddr] <= wdata;
  assign rdata_a   = regs[ra];
  assign rdata_b   = regs[rb];
  assign dbg_rdata = regs[dbg_raddr];
endmodule

// File: rtl/multicycle_proc_core.sv
// multicycle_proc_core: fetch/execute core with external instruction fetch handshake
module multicycle_proc_core import mcp_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int PC_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_valid,
  input  logic [15:0]              imem_data,
  output logic [PC_W-1:0]          pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     wb_valid,
  output logic [$clog2(NREGS)-1:0] wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [DATA_W-1:0]        dbg_rdata
);
  localparam int AW = $clog2(NREGS);
  state_t state;
  logic [15:0] ir;
  logic [3:0] op;
  logic [AW-1:0] rd, rs, rt;
  logic [DATA_W-1:0] a, b, imm, res;
  logic [DATA_W:0] sum, dif;
  logic [PC_W-1:0] next_pc;
  logic is_alu, is_arith, writes, unused_ir;
  assign op        = ir[OP_LSB +: 4];
  assign rd        = ir[RD_LSB +: AW];
  assign rs        = ir[RS_LSB +: AW];
  assign rt        = ir[RT_LSB +: AW];
  assign imm       = DATA_W'(ir[IMM_W-1:0]);
  assign unused_ir = ^ir;
  assign is_alu    = op >= OP_ADD && op <= OP_XOR;
  assign is_arith  = op == OP_ADD || op == OP_SUB;
  assign writes    = op >= OP_ADD && op <= OP_LDI;
  assign sum       = {1'b0, a} + {1'b0, b};
  assign dif       = {1'b0, a} - {1'b0, b};
  assign res       = op == OP_ADD ? sum[DATA_W-1:0] :
                     op == OP_SUB ? dif[DATA_W-1:0] :
                     op == OP_OR  ? a | b :
                     op == OP_AND ? a & b :
                     op == OP_XOR ? a ^ b : imm;
  assign next_pc   = (op == OP_JMP || (op == OP_BZ && flag_z)) ? PC_W'(ir[IMM_W-1:0]) : pc + 1'b1;
  assign imem_req  = state == FETCH;
  assign imem_addr = pc;
  assign busy      = state != IDLE;
  mcp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk, .rst,
    .we(state == EXEC && writes),
    .waddr(rd), .wdata(res),
    .ra(rs), .rb(rt), .dbg_raddr,
    .rdata_a(a), .rdata_b(b), .dbg_rdata
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      halted   <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state  <= FETCH;
          halted <= 1'b0;
        end
        FETCH: if (imem_valid) begin
          ir    <= imem_data;
          state <= EXEC;
        end
        EXEC: begin
          pc       <= next_pc;
          state    <= op == OP_HALT ? IDLE : FETCH;
          halted   <= op == OP_HALT;
          illegal  <= op > OP_HALT;
          wb_valid <= writes;
          if (writes) begin
            wb_addr <= rd;
            wb_data <= res;
          end
          if (is_alu) flag_z <= res == '0;
          if (is_arith) flag_c <= op == OP_ADD ? sum[DATA_W] : dif[DATA_W];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/multicycle_proc_core.md
Name: multicycle_proc_core

Overview:
- Parametrised successor to the single-cycle 8-bit datapath: multi-cycle fetch/execute core with configurable data width, register count and PC width.
- Adds external instruction-fetch handshake, immediate load, jump, conditional branch, halt/start control, flags and illegal-opcode reporting.
- Sits under the TinyTapeout top level. Instruction memory is external to the core (ROM or ui_in-driven loader).

Parameters:
- DATA_W, 8, datapath and register width; legal range 8..32.
- NREGS, 4, number of general registers; power of two, 2..16.
- PC_W, 8, program counter width; legal range 4..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; IDLE -> FETCH. Ignored in other states.
- imem_req  out  1  fetch request; high throughout FETCH.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_valid  in  1  instruction valid; sampled only while imem_req=1.
- imem_data  in  16  instruction word.
- pc  out  PC_W  current program counter.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in IDLE after a HALT has executed. Cleared by start or rst.
- wb_valid  out  1  one-cycle pulse on each register write.
- wb_addr  out  clog2(NREGS)  register written.
- wb_data  out  DATA_W  value written.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry (ADD) / borrow (SUB) flag.
- illegal  out  1  one-cycle pulse when an undefined opcode executes.
- dbg_raddr  in  clog2(NREGS)  debug register read address.
- dbg_rdata  out  DATA_W  combinational read of register[dbg_raddr].

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything, including mid-fetch or mid-exec):
  - state=IDLE, pc=0, ir=0.
  - All registers 0.
  - flag_z=0, flag_c=0, halted=0.
  - wb_valid=0, wb_addr=0, wb_data=0, illegal=0, imem_req=0.
- Instruction format: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0].
  - Register fields use their low clog2(NREGS) bits; upper bits are ignored.
  - imm8 is zero-extended to DATA_W, and truncated to PC_W for jump targets.
- States:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1. On an edge with imem_valid=1: ir<=imem_data, go to EXEC. Otherwise wait indefinitely; pc stays stable.
  - EXEC: one cycle. Performs the operation, then pc<=next_pc. Goes to FETCH, or to IDLE with halted<=1 for HALT.
- Minimum throughput: 2 cycles per instruction, when imem_valid is already high on entry to FETCH.
- Opcodes (registers read from the current register file; result written at the end of EXEC):
  - 0 NOP.
  - 1 ADD: rd=rs+rt. flag_c=carry out of bit DATA_W-1.
  - 2 SUB: rd=rs-rt. flag_c=1 iff rs<rt (unsigned borrow).
  - 3 OR, 4 AND, 5 XOR: rd=rs op rt. flag_c unchanged.
  - 6 LDI: rd=imm8. Flags unchanged.
  - 7 JMP: next_pc=imm8.
  - 8 BZ: next_pc=imm8 if flag_z=1, else pc+1.
  - 9 HALT: next_pc=pc+1, then go to IDLE.
  - 10-15 illegal: behave as NOP and pulse illegal=1 for one cycle.
- Flag rules: flag_z updates only on ALU ops 1-5 (z = result==0). Flag_c updates only on ADD and SUB.
- Arithmetic is modulo 2^DATA_W.
- pc+1 wraps from 2^PC_W-1 to 0 with no flag or error.
- wb_valid/wb_addr/wb_data are registered. They pulse in the cycle after EXEC, and only for ops 1-6.
- rd==rs (or rd==rt) is allowed: the operand is the old value.
- start while busy is ignored. start in the same cycle as rst is ignored (reset wins).
- A HALT followed by start resumes from the saved pc (the address after the HALT).
- dbg_rdata reflects a register write from the clock edge onward.

Decomposition:
- Package mcp_pkg:
  - Opcode localparams (OP_NOP..OP_HALT).
  - State enum (IDLE, FETCH, EXEC).
  - Instruction field bit positions.
- One sub-module: mcp_regfile. NREGS x DATA_W, synchronous write, two combinational read ports plus the debug read port, synchronous reset to 0.
- ALU and FSM stay in the core.

Test Plan:
- Default params; rst; start; memory always valid; program LDI r1,0x05 / LDI r2,0x03 / ADD r3,r1,r2 / HALT.
  - Expect wb pulses (1,05), (2,03), (3,08).
  - Halted=1 and pc=4 after 8 busy cycles.
- LDI r1,0x03 / LDI r2,0x05 / SUB r0,r1,r2.
  - Expect r0=0xFE, flag_c=1, flag_z=0.
  - Then SUB r0,r1,r1: expect r0=0, flag_z=1, flag_c=0.
- LDI r1,0xFF / LDI r2,0x01 / ADD r3,r1,r2 / BZ 0x10.
  - Expect r3=0, flag_c=1, next imem_addr=0x10.
  - Repeat with r2=0x02: expect r3=0x01 and fall-through imem_addr=4.
- imem_valid held low 5 cycles in FETCH.
  - Expect imem_req=1, imem_addr constant, no wb pulse, no state change.
  - Then one valid cycle proceeds normally.
- Opcode 0xC000 executed.
  - Expect illegal pulse for exactly 1 cycle, no writes, flags unchanged, pc+1.
- JMP 0xFF then NOP at 0xFF: expect pc wraps to 0.
- Assert rst during EXEC of an ADD: no wb pulse, all outputs at reset values, start is required to restart.
- DATA_W=16, NREGS=8: ADD of 0xFFFF+0x0001 gives wb_data=0x0000 and flag_c=1; rd field 0xF maps to r7.
